norm_shiftleft24: RTL and testbench
===================================

NORM_SHIFTLEFT24 -- requirements
Module: norm_shiftleft24

Interface
REQ-001 The block SHALL have no parameters; widths come from the shared package (MANT_W=24, EXP_W=8, LZC_W=5).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 in_sign  input  1  sign, passed through.
REQ-008 in_exp  input  8  biased exponent before normalization.
REQ-009 in_mant  input  24  unnormalized mantissa, bit 23 = hidden-bit position.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_sign  output  1  sign.
REQ-013 out_exp  output  8  normalized biased exponent.
REQ-014 out_mant  output  24  normalized mantissa.
REQ-015 out_zero  output  1  in_mant was zero.
REQ-016 out_uflow  output  1  result denormal: full normalization would need exponent <1.

Function
REQ-017 The block SHALL be a 2-stage valid/ready pipeline. Stage 1 registers sign, exp, mant and lzc (leading-zero count of in_mant, 0..24). Stage 2 registers the shifted result.
REQ-018 Latency SHALL be 2 cycles from an accepted input (in_valid&in_ready) to out_valid, with no backpressure. Throughput SHALL be 1 beat/cycle.
REQ-019 A stage SHALL load when its input is valid and it is empty or its contents are leaving this cycle. in_ready = !s1_valid | s2_advance, where s2_advance = !s2_valid | out_ready.
REQ-020 While out_valid=1 and out_ready=0, all out_* SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-021 Zero (in_mant=0): out_mant=0, out_exp=0, out_zero=1, out_uflow=0.
REQ-022 Normal case, in_exp > lzc: shift = lzc, out_exp = in_exp - lzc, out_uflow=0.
REQ-023 Underflow case, 1 <= in_exp <= lzc: shift = in_exp-1, out_exp=0, out_uflow=1.
REQ-024 in_exp=0 with nonzero mant: shift=0, out_exp=0, out_mant=in_mant, out_uflow=1.
REQ-025 The left shift SHALL be logical, zero-filling from bit 0. The shift amount SHALL never exceed 23 for a nonzero mantissa.
REQ-026 out_sign SHALL equal in_sign of the same beat in every case.
REQ-027 Simultaneous accept at the input and drain at the output in one cycle SHALL move both beats correctly.

Reset
REQ-028 With rst_n low: s1_valid=0, out_valid=0, out_mant=0, out_exp=0, out_sign=0, out_zero=0, out_uflow=0, and in_ready=1 one cycle after release.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight beats immediately. No out_valid SHALL appear for beats accepted before reset.

Structure
REQ-030 MANT_W, EXP_W and LZC_W SHALL live in the shared FPU package.
REQ-031 The left shift SHALL be a sub-module shiftleft24 (out, in, sel[4:0]). It SHALL be a 5-stage log shifter (16/8/4/2/1), the mirror of the existing right shifter.
REQ-032 The LZC SHALL be combinational in stage 1. All other logic outside shiftleft24 SHALL be in this module.

Verification
REQ-033 Input mant=0x000001, exp=100 -> out_mant=0x800000, out_exp=77, out_uflow=0, valid 2 cycles later.
REQ-034 Input mant=0x0000F0, exp=10 -> out_mant=0x01E000, out_exp=0, out_uflow=1. Input mant=0x400000, exp=0 -> out_mant=0x400000, out_exp=0, out_uflow=1.
REQ-035 Input mant=0, exp=0x55, sign=1 -> out_mant=0, out_exp=0, out_zero=1, out_sign=1. Input mant=0x800000, exp=1 -> unchanged, flags 0.
REQ-036 Stream 8 back-to-back beats with out_ready low for cycles 3-6. Required: in_ready drops within 1 cycle, outputs hold stable, and all 8 results exit in order with none lost.
REQ-037 Pull rst_n low with 2 beats in flight -> out_valid=0 immediately. After release, only new beats emerge.

Source files
------------

// File: rtl/norm_shiftleft24_pkg.sv
// Shared FPU widths, pipeline beat types and the leading-zero counter used by the normalizer.
package norm_shiftleft24_pkg;

   localparam int MANT_W = 24;
   localparam int EXP_W  = 8;
   localparam int LZC_W  = 5;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MANT_W-1:0] mant;
      logic [LZC_W-1:0] lzc;
   } s1_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MANT_W-1:0] mant;
      logic             zero;
      logic             uflow;
   } res_t;

   // Scanning upward lets the highest set bit win; an all-zero mantissa yields MANT_W.
   function automatic logic [LZC_W-1:0] lzc24(input logic [MANT_W-1:0] m);
      logic [LZC_W-1:0] cnt;
      cnt = LZC_W'(MANT_W);
      for (int i = 0; i < MANT_W; i++) begin
         if (m[i]) cnt = LZC_W'(MANT_W - 1 - i);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/norm_shiftleft24_if.sv
// Valid/ready input and output channels of the normalizer; master drives the input side.
interface norm_shiftleft24_if;
   import norm_shiftleft24_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic [EXP_W-1:0]  in_exp;
   logic [MANT_W-1:0] in_mant;
   logic              out_valid;
   logic              out_ready;
   logic              out_sign;
   logic [EXP_W-1:0]  out_exp;
   logic [MANT_W-1:0] out_mant;
   logic              out_zero;
   logic              out_uflow;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_uflow
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_uflow
   );

endinterface

// File: rtl/norm_shiftleft24_shl.sv
// shiftleft24: combinational 5-level logarithmic left shifter (16/8/4/2/1), zero-filling from bit 0.
// Mirror of the right shifter; no state, no handshake.
module shiftleft24
   import norm_shiftleft24_pkg::*;
(
   output logic [MANT_W-1:0] out,
   input  logic [MANT_W-1:0] in,
   input  logic [LZC_W-1:0]  sel
);

   logic [MANT_W-1:0] st16, st8, st4, st2;

   assign st16 = sel[4] ? (in   << 16) : in;
   assign st8  = sel[3] ? (st16 << 8)  : st16;
   assign st4  = sel[2] ? (st8  << 4)  : st8;
   assign st2  = sel[1] ? (st4  << 2)  : st4;
   assign out  = sel[0] ? (st2  << 1)  : st2;

endmodule

// File: rtl/norm_shiftleft24.sv
// Mantissa normalizer: 2-stage valid/ready pipeline (LZC in stage 1, clamped shift in stage 2), 2-cycle latency.
// Full throughput; a stalled output holds stable and backpressure reaches in_ready in the same cycle.
module norm_shiftleft24
   import norm_shiftleft24_pkg::*;
(
   input logic              clk,
   input logic              rst_n,
   norm_shiftleft24_if.slave bus
);

   s1_t              s1_d, s1_q;
   logic             s1_valid_d, s1_valid_q;
   res_t             s2_d, s2_q;
   logic             s2_valid_d, s2_valid_q;
   logic             s2_advance;
   logic             in_ready;
   logic [LZC_W-1:0] shamt;
   logic [MANT_W-1:0] shifted;

   assign s2_advance = !s2_valid_q || bus.out_ready;
   assign in_ready   = !s1_valid_q || s2_advance;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      if (in_ready) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_d.sign = bus.in_sign;
            s1_d.exp  = bus.in_exp;
            s1_d.mant = bus.in_mant;
            s1_d.lzc  = lzc24(bus.in_mant);
         end
      end
   end

   // Shift is clamped so the exponent never goes below 1; the excess becomes a denormal.
   always_comb begin
      shamt      = '0;
      s2_d       = s2_q;
      s2_valid_d = s2_valid_q;
      if (s1_q.mant == '0) begin
         shamt = '0;
      end else if (s1_q.exp == '0) begin
         shamt = '0;
      end else if (s1_q.exp > EXP_W'(s1_q.lzc)) begin
         shamt = s1_q.lzc;
      end else begin
         shamt = LZC_W'(s1_q.exp - EXP_W'(1));
      end
      if (s2_advance) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_d.sign  = s1_q.sign;
            s2_d.mant  = shifted;
            s2_d.zero  = (s1_q.mant == '0);
            s2_d.uflow = (s1_q.mant != '0) && (s1_q.exp <= EXP_W'(s1_q.lzc));
            s2_d.exp   = ((s1_q.mant != '0) && (s1_q.exp > EXP_W'(s1_q.lzc)))
                         ? s1_q.exp - EXP_W'(s1_q.lzc) : '0;
         end
      end
   end

   shiftleft24 u_shl (
      .out (shifted),
      .in  (s1_q.mant),
      .sel (shamt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         s2_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         s2_q       <= s2_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_sign  = s2_q.sign;
   assign bus.out_exp   = s2_q.exp;
   assign bus.out_mant  = s2_q.mant;
   assign bus.out_zero  = s2_q.zero;
   assign bus.out_uflow = s2_q.uflow;

endmodule

// File: tb/tb_norm_shiftleft24.sv
// Bench for norm_shiftleft24: directed corner beats, a stalled stream, random traffic and mid-flight reset.
module tb_norm_shiftleft24;
   import norm_shiftleft24_pkg::*;

   logic clk;
   logic rst_n;
   norm_shiftleft24_if bus();

   norm_shiftleft24 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   res_t q[$];
   int   got = 0;
   logic acc = 1'b0;
   logic last_ir = 1'b0;
   logic hold_prev = 1'b0;
   res_t prev_out;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference result from the normalization rules: find the MSB, shift it to bit 23 unless exp would drop below 1.
   function automatic res_t ref_model(input logic s, input logic [7:0] e, input logic [23:0] m);
      res_t   r;
      int     msb, lz, sh;
      longint p;
      r = '0;
      r.sign = s;
      if (m == 0) begin
         r.zero = 1'b1;
         return r;
      end
      msb = $clog2(int'(m) + 1) - 1;
      lz  = 23 - msb;
      if (e == 0) begin
         r.uflow = 1'b1;
         r.mant  = m;
      end else if (int'(e) > lz) begin
         r.exp = 8'(int'(e) - lz);
         p = longint'(m) * (longint'(1) << lz);
         r.mant = p[23:0];
      end else begin
         r.uflow = 1'b1;
         sh = int'(e) - 1;
         p = longint'(m) * (longint'(1) << sh);
         r.mant = p[23:0];
      end
      return r;
   endfunction

   function automatic res_t cur_out();
      res_t r;
      r = {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_zero, bus.out_uflow};
      return r;
   endfunction

   task automatic tick();
      res_t e;
      @(negedge clk);
      acc = 1'b0;
      last_ir = bus.in_ready;
      if (rst_n) begin
         if (hold_prev) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", cur_out(), prev_out);
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(ref_model(bus.in_sign, bus.in_exp, bus.in_mant));
            acc = 1'b1;
         end
         if (bus.out_valid && bus.out_ready) begin
            got++;
            chk("out_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("result", cur_out(), e);
            end
         end
         hold_prev = bus.out_valid && !bus.out_ready;
         prev_out  = cur_out();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_dir(input logic s, input logic [7:0] e, input logic [23:0] m, output int lat);
      bus.in_valid = 1'b1;
      bus.in_sign  = s;
      bus.in_exp   = e;
      bus.in_mant  = m;
      tick();
      chk("dir_accept", acc, 1);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat;
      int sent;
      int ir_high_stall;
      logic [23:0] m;
      logic [7:0]  e;

      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sign  = 1'b0;
      bus.in_exp   = '0;
      bus.in_mant  = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_fields", cur_out(), '0);
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready", bus.in_ready, 1);

      // Directed corner beats
      send_dir(1'b0, 8'd100, 24'h000001, lat);
      chk("d1_latency", lat, 2);
      chk("d1_mant", bus.out_mant, 24'h800000);
      chk("d1_exp", bus.out_exp, 8'd77);
      chk("d1_uflow", bus.out_uflow, 0);
      send_dir(1'b0, 8'd10, 24'h0000F0, lat);
      chk("d2_mant", bus.out_mant, 24'h01E000);
      chk("d2_exp", bus.out_exp, 0);
      chk("d2_uflow", bus.out_uflow, 1);
      send_dir(1'b1, 8'd0, 24'h400000, lat);
      chk("d3_mant", bus.out_mant, 24'h400000);
      chk("d3_exp", bus.out_exp, 0);
      chk("d3_uflow", bus.out_uflow, 1);
      chk("d3_sign", bus.out_sign, 1);
      send_dir(1'b1, 8'h55, 24'h000000, lat);
      chk("d4_mant", bus.out_mant, 0);
      chk("d4_exp", bus.out_exp, 0);
      chk("d4_zero", bus.out_zero, 1);
      chk("d4_uflow", bus.out_uflow, 0);
      chk("d4_sign", bus.out_sign, 1);
      send_dir(1'b0, 8'd1, 24'h800000, lat);
      chk("d5_mant", bus.out_mant, 24'h800000);
      chk("d5_exp", bus.out_exp, 1);
      chk("d5_flags", {bus.out_zero, bus.out_uflow}, 0);
      tick();
      chk("dir_drained", q.size(), 0);

      // 8 back-to-back beats with the output stalled on cycles 3-6
      got = 0;
      sent = 0;
      ir_high_stall = 0;
      for (int c = 0; c < 60 && (sent < 8 || q.size() != 0); c++) begin
         bus.out_ready = !(c >= 3 && c <= 6);
         if (sent < 8) begin
            bus.in_valid = 1'b1;
            bus.in_sign  = sent[0];
            bus.in_exp   = 8'(20 + 3 * sent);
            bus.in_mant  = 24'h000100 << sent;
         end else begin
            bus.in_valid = 1'b0;
         end
         tick();
         if (acc) sent++;
         if (c >= 4 && c <= 6 && last_ir) ir_high_stall++;
      end
      chk("stream_sent", sent, 8);
      chk("stream_got", got, 8);
      chk("stream_stall_in_ready", ir_high_stall, 0);
      bus.out_ready = 1'b1;

      // Random traffic with random backpressure
      bus.in_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!bus.in_valid || acc) begin
            m = 24'($urandom()) >> $urandom_range(0, 24);
            e = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 26)) : 8'($urandom());
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_sign  = 1'($urandom());
            bus.in_exp   = e;
            bus.in_mant  = m;
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 20 && q.size() != 0; c++) tick();
      chk("random_drained", q.size(), 0);

      // Reset with two beats in flight
      bus.out_ready = 1'b0;
      send_dir(1'b1, 8'd50, 24'h000FFF, lat);
      bus.in_valid = 1'b1;
      bus.in_exp   = 8'd60;
      bus.in_mant  = 24'h00ABCD;
      tick();
      chk("flight_accept", acc, 1);
      bus.in_valid = 1'b0;
      chk("flight_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_fields", cur_out(), '0);
      q.delete();
      hold_prev = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      chk("post_rst_in_ready", bus.in_ready, 1);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("post_rst_no_stale", bus.out_valid, 0);
      end
      send_dir(1'b0, 8'd30, 24'h123456, lat);
      chk("post_rst_latency", lat, 2);
      chk("post_rst_mant", bus.out_mant, 24'h91A2B0);
      chk("post_rst_exp", bus.out_exp, 8'd27);
      tick();
      chk("final_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
